conv_window_fetch: RTL and testbench
====================================

// Module: conv_window_fetch
// PURPOSE
// - RAM-side responder to the convolution controller's 3x3 window read handshake.
// - Accepts a start pulse, the 9 packed tap addresses and the centre pixel address.
// - Reads the 9 taps one per cycle from a single-read-port feature RAM and zero-pads taps outside the 64x64 image.
// - Returns the assembled window with a one-cycle valid pulse; sits between the controller and the source RAM.
// PARAMETERS
// - DATA_W    8   pixel width in bits
// - ADDR_W    12  RAM address width; the image holds 2^ADDR_W pixels
// - COL_BITS  6   low address bits holding the column (row = upper ADDR_W-COL_BITS bits)
// - RAM_LAT   1   RAM read latency in cycles, from o_ramEn to i_ramData valid; legal range 1..4
// - PAD_EN    1   1: zero-pad out-of-image taps; 0: read every tap as addressed (wrap-around)
// PORTS
// - i_clk        in   1          clock, rising edge
// - i_reset      in   1          asynchronous reset, active-low
// - i_start      in   1          start pulse from the controller
// - i_addr       in   9*ADDR_W   tap addresses; tap k in [k*ADDR_W +: ADDR_W]; tap 4 is the centre
// - i_centerAddr in   ADDR_W     centre pixel address, used for the padding decision
// - o_ramEn      out  1          RAM read enable
// - o_ramAddr    out  ADDR_W     RAM read address
// - i_ramData    in   DATA_W     RAM read data, valid RAM_LAT cycles after o_ramEn
// - o_window     out  9*DATA_W   assembled window; tap k in [k*DATA_W +: DATA_W]
// - o_valid      out  1          one-cycle pulse: o_window is complete (drives the controller's i_validRam)
// - o_busy       out  1          high from start acceptance through the o_valid cycle
// BEHAVIOUR
// - Reset values: o_ramEn=0, o_ramAddr=0, o_window=0, o_valid=0, o_busy=0; the FSM is in IDLE.
// - FSM states: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
// - IDLE: on i_start=1, latch i_addr and i_centerAddr, clear the tap counter, go to ISSUE. i_start is ignored in all other states.
// - ISSUE: one tap k per cycle, k = 0..8, always 9 cycles.
//   - Tap not padded: o_ramEn=1, o_ramAddr=addr[k].
//   - Tap padded: o_ramEn=0, o_ramAddr=0, window[k] written to 0 in that cycle.
//   - After k=8, go to DRAIN.
// - Tag pipeline: a RAM_LAT-deep shift register of {live, k}. When live=1 at the output, capture i_ramData into window[k].
// - DRAIN: wait RAM_LAT cycles for the last tag to exit, then go to DONE.
// - DONE: o_valid=1 for exactly one cycle, then IDLE.
// - Fixed latency: start-accept cycle = 0; ISSUE occupies cycles 1..9; o_valid is high at cycle 10+RAM_LAT (11 at default). Padding does not change latency.
// - o_window holds its value from o_valid until the next accepted start. Taps are overwritten in place during the next fetch.
// - Padding rule (PAD_EN=1), with row = centre[ADDR_W-1:COL_BITS] and col = centre[COL_BITS-1:0]; max = all-ones:
//   - row==0: pad taps 0,1,2.
//   - row==max: pad taps 6,7,8.
//   - col==0: pad taps 0,3,6.
//   - col==max: pad taps 2,5,8.
//   - Corners take the union of the row and column rules.
// - Addresses are used modulo 2^ADDR_W with no range check.
// - Reset mid-operation: return to IDLE immediately. In-flight tags are discarded, all outputs return to reset values, and no o_valid is issued.
// - i_start in the DONE cycle is ignored; the controller must re-pulse it.
// STRUCTURE
// - Shared package conv_pkg holds:
//   - TAP_CNT=9 and CENTER_TAP=4
//   - state encoding: IDLE=0, ISSUE=1, DRAIN=2, DONE=3
//   - the image geometry constants
// - One sub-module, conv_rd_tag_pipe: a parameterised RAM_LAT-deep {live, tap[3:0]} shift register with async active-low clear.
// - Padding mask is combinational from the latched centre address; 9-bit mask registered at start acceptance.
// TESTING
// - T1 interior: centre 0x821, RAM[a]=a[7:0].
//   - Expect o_valid at cycle 11 and window = {0x62,0x61,0x60,0x22,0x21,0x20,0xE2,0xE1,0xE0} (tap8..tap0).
//   - Expect exactly 9 o_ramEn cycles, on cycles 1..9.
// - T2 corner: centre 0x000, PAD_EN=1.
//   - Taps 0,1,2,3,6 = 0, no o_ramEn for those taps; taps 4,5,7,8 = RAM[0x000,0x001,0x040,0x041].
//   - o_valid still at cycle 11.
// - T3 corner: centre 0xFFF.
//   - Taps 2,5,6,7,8 = 0; tap 0 = RAM[0xFBE].
//   - Same test with PAD_EN=0: all 9 reads issued, tap 8 = RAM[0x040] (wrap).
// - T4 latency: RAM_LAT=3, interior centre.
//   - o_valid at cycle 13; data correctly aligned per tap.
// - T5 ignored starts: i_start pulsed at cycles 4 and 11.
//   - No second fetch and no o_ramEn after cycle 9; exactly one o_valid.
// - T6 reset mid-operation: i_reset=0 at cycle 5, released at cycle 7, new start at cycle 8.
//   - No o_valid before cycle 19; the window holds only the new fetch.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the 3x3 convolution window fetch path.
// Holds tap counts, FSM encoding, image geometry, read tags and the pad mask helper.
package conv_pkg;

   localparam int TAP_CNT    = 9;
   localparam int CENTER_TAP = 4;

   localparam int IMG_COLS = 64;
   localparam int IMG_ROWS = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } fetch_state_e;

   typedef struct packed {
      logic       live;
      logic [3:0] tap;
   } rd_tag_t;

   // Taps 0..8 are row-major with tap 4 at the centre.
   function automatic logic [8:0] pad_mask(
      input logic row_zero,
      input logic row_max,
      input logic col_zero,
      input logic col_max
   );
      logic [8:0] m;
      m = '0;
      if (row_zero) m = m | 9'b000_000_111;
      if (row_max)  m = m | 9'b111_000_000;
      if (col_zero) m = m | 9'b001_001_001;
      if (col_max)  m = m | 9'b100_100_100;
      return m;
   endfunction

endpackage

// File: rtl/conv_rd_tag_pipe.sv
// Read tag delay line matching the feature RAM latency.
// Ports: i_clk, i_reset (async active-low clear), i_tag in, o_tag out DEPTH cycles later.
module conv_rd_tag_pipe
   import conv_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic    i_clk,
   input  logic    i_reset,
   input  rd_tag_t i_tag,
   output rd_tag_t o_tag
);

   rd_tag_t [DEPTH-1:0] pipe_q;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         pipe_q <= '0;
      end else begin
         pipe_q[0] <= i_tag;
         for (int i = 1; i < DEPTH; i++) begin
            pipe_q[i] <= pipe_q[i-1];
         end
      end
   end

   assign o_tag = pipe_q[DEPTH-1];

endmodule

// File: rtl/conv_window_fetch.sv
// Fetches a 3x3 window from a single-port feature RAM, one tap per cycle, zero-padding edges.
// Ports: i_start/i_addr/i_centerAddr request; o_ramEn/o_ramAddr/i_ramData RAM; o_window/o_valid/o_busy result.
module conv_window_fetch
   import conv_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 12,
   parameter int COL_BITS = 6,
   parameter int RAM_LAT  = 1,
   parameter int PAD_EN   = 1
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [9*ADDR_W-1:0]   i_addr,
   input  logic [ADDR_W-1:0]     i_centerAddr,
   output logic                  o_ramEn,
   output logic [ADDR_W-1:0]     o_ramAddr,
   input  logic [DATA_W-1:0]     i_ramData,
   output logic [9*DATA_W-1:0]   o_window,
   output logic                  o_valid,
   output logic                  o_busy
);

   localparam int ROW_BITS = ADDR_W - COL_BITS;

   fetch_state_e          state_q, state_d;
   logic [3:0]            tap_q, tap_d;
   logic [2:0]            drain_q, drain_d;
   logic [9*ADDR_W-1:0]   addr_q;
   logic [8:0]            mask_q, mask_d;
   logic [9*DATA_W-1:0]   win_q;

   logic                  accept;
   logic                  ram_en;
   logic [ADDR_W-1:0]     ram_addr;
   logic                  pad_clr;
   logic                  valid;
   rd_tag_t               tag_in, tag_out;

   logic [ROW_BITS-1:0]   row;
   logic [COL_BITS-1:0]   col;

   assign row = i_centerAddr[ADDR_W-1:COL_BITS];
   assign col = i_centerAddr[COL_BITS-1:0];

   always_comb begin
      mask_d = '0;
      if (PAD_EN != 0) begin
         mask_d = pad_mask(row == '0, &row, col == '0, &col);
      end
   end

   always_comb begin
      state_d  = state_q;
      tap_d    = tap_q;
      drain_d  = drain_q;
      accept   = 1'b0;
      ram_en   = 1'b0;
      ram_addr = '0;
      pad_clr  = 1'b0;
      valid    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_start) begin
               accept  = 1'b1;
               tap_d   = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            pad_clr = mask_q[tap_q];
            ram_en  = !mask_q[tap_q];
            if (ram_en) begin
               ram_addr = addr_q[int'(tap_q)*ADDR_W +: ADDR_W];
            end
            tap_d = tap_q + 4'd1;
            if (tap_q == 4'(TAP_CNT-1)) begin
               drain_d = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // Counts the RAM_LAT cycles until the tap-8 tag leaves the pipe.
            drain_d = drain_q + 3'd1;
            if (drain_q == 3'(RAM_LAT-1)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            valid   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign tag_in = '{live: ram_en, tap: tap_q};

   conv_rd_tag_pipe #(
      .DEPTH (RAM_LAT)
   ) u_tag_pipe (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_tag   (tag_in),
      .o_tag   (tag_out)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q <= IDLE;
         tap_q   <= '0;
         drain_q <= '0;
         addr_q  <= '0;
         mask_q  <= '0;
         win_q   <= '0;
      end else begin
         state_q <= state_d;
         tap_q   <= tap_d;
         drain_q <= drain_d;
         if (accept) begin
            addr_q <= i_addr;
            mask_q <= mask_d;
         end
         if (pad_clr) begin
            win_q[int'(tap_q)*DATA_W +: DATA_W] <= '0;
         end
         if (tag_out.live) begin
            win_q[int'(tag_out.tap)*DATA_W +: DATA_W] <= i_ramData;
         end
      end
   end

   assign o_ramEn   = ram_en;
   assign o_ramAddr = ram_addr;
   assign o_window  = win_q;
   assign o_valid   = valid;
   assign o_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_conv_window_fetch.sv
// Bench for conv_window_fetch: three configurations against a transaction-level window model.
// Directed edge/latency/reset cases pinned with literals, then randomized traffic.
module tb_conv_window_fetch;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst_n;
   logic                 start;
   logic [107:0]         addr;
   logic [11:0]          cen;

   logic [2:0]           en_w, val_w, busy_w;
   logic [2:0][11:0]     ad_w;
   logic [2:0][71:0]     win_w;
   logic [2:0][7:0]      rdat;
   logic [2:0][3:0][7:0] rp;

   logic [7:0] mem [4096];
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int latof(input int i);
      return (i == 1) ? 3 : 1;
   endfunction

   function automatic bit padof(input int i);
      return (i != 2);
   endfunction

   conv_window_fetch #(.RAM_LAT(1), .PAD_EN(1)) u0 (
      .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_addr(addr),
      .i_centerAddr(cen), .o_ramEn(en_w[0]), .o_ramAddr(ad_w[0]),
      .i_ramData(rdat[0]), .o_window(win_w[0]), .o_valid(val_w[0]),
      .o_busy(busy_w[0]));

   conv_window_fetch #(.RAM_LAT(3), .PAD_EN(1)) u1 (
      .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_addr(addr),
      .i_centerAddr(cen), .o_ramEn(en_w[1]), .o_ramAddr(ad_w[1]),
      .i_ramData(rdat[1]), .o_window(win_w[1]), .o_valid(val_w[1]),
      .o_busy(busy_w[1]));

   conv_window_fetch #(.RAM_LAT(1), .PAD_EN(0)) u2 (
      .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_addr(addr),
      .i_centerAddr(cen), .o_ramEn(en_w[2]), .o_ramAddr(ad_w[2]),
      .i_ramData(rdat[2]), .o_window(win_w[2]), .o_valid(val_w[2]),
      .o_busy(busy_w[2]));

   // RAM: garbage on the bus whenever no read was issued.
   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         rp[i][0] <= en_w[i] ? mem[ad_w[i]] : 8'($urandom);
         for (int j = 1; j < 4; j++) rp[i][j] <= rp[i][j-1];
      end
   end

   always_comb begin
      rdat = '0;
      for (int i = 0; i < 3; i++) rdat[i] = rp[i][latof(i)-1];
   end

   function automatic logic [8:0] pmask(input logic [11:0] c, input bit pe);
      int row, col, dr, dc;
      logic [8:0] m;
      row = int'(c[11:6]);
      col = int'(c[5:0]);
      m = '0;
      for (int k = 0; k < 9; k++) begin
         dr = k / 3 - 1;
         dc = k % 3 - 1;
         if (pe && ((row == 0 && dr < 0) || (row == 63 && dr > 0) ||
                    (col == 0 && dc < 0) || (col == 63 && dc > 0)))
            m[k] = 1'b1;
      end
      return m;
   endfunction

   function automatic logic [71:0] mwin(input logic [107:0] a, input logic [8:0] m);
      logic [71:0] w;
      w = '0;
      for (int k = 0; k < 9; k++)
         if (!m[k]) w[k*8 +: 8] = mem[a[k*12 +: 12]];
      return w;
   endfunction

   function automatic logic [107:0] nb(input logic [11:0] c);
      logic [107:0] a;
      for (int k = 0; k < 9; k++)
         a[k*12 +: 12] = 12'(int'(c) + (k / 3 - 1) * 64 + (k % 3 - 1));
      return a;
   endfunction

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input int i,
                      input logic [71:0] got, input logic [71:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s u%0d cyc=%0d got=%h exp=%h", nm, i, cyc, got, exp);
      end
   endtask

   bit            act [3];
   int            c0 [3];
   logic [107:0]  la [3];
   logic [8:0]    lm [3];
   logic [71:0]   ew [3];
   int            ecnt [3];
   int            vcnt [3];
   int            vrel [3];

   bit            pin_go;
   int            pin_i, pin_rel, pin_nen;
   logic [71:0]   pin_win;

   always @(negedge clk) begin : cmp
      int t, L, k;
      logic e_en, e_v, e_b;
      logic [11:0] e_ad;
      for (int i = 0; i < 3; i++) begin
         L = latof(i);
         t = cyc - c0[i];
         if (!rst_n) begin
            act[i] = 1'b0;
            ew[i]  = '0;
         end
         if (act[i] && t > 10 + L) act[i] = 1'b0;
         e_en = 1'b0;
         e_ad = '0;
         e_v  = 1'b0;
         e_b  = 1'b0;
         if (act[i]) begin
            e_b = 1'b1;
            if (t >= 1 && t <= 9) begin
               k = t - 1;
               e_en = !lm[i][k];
               if (e_en) e_ad = la[i][k*12 +: 12];
            end
            e_v = (t == 10 + L);
         end
         chk("ramEn", i, 72'(en_w[i]), 72'(e_en));
         chk("ramAddr", i, 72'(ad_w[i]), 72'(e_ad));
         chk("valid", i, 72'(val_w[i]), 72'(e_v));
         chk("busy", i, 72'(busy_w[i]), 72'(e_b));
         if (!act[i] || t >= 10 + L) chk("window", i, win_w[i], ew[i]);
         if (en_w[i]) ecnt[i]++;
         if (val_w[i]) begin
            vcnt[i]++;
            vrel[i] = t;
         end
         if (pin_go && pin_i == i) begin
            chk("pin_window", i, win_w[i], pin_win);
            chk("pin_model", i, ew[i], pin_win);
            chk("pin_vcyc", i, 72'(vrel[i]), 72'(pin_rel));
            chk("pin_reads", i, 72'(ecnt[i]), 72'(pin_nen));
            chk("pin_nvalid", i, 72'(vcnt[i]), 72'(1));
         end
         if (rst_n && start && !act[i]) begin
            act[i]  = 1'b1;
            c0[i]   = cyc;
            la[i]   = addr;
            lm[i]   = pmask(cen, padof(i));
            ew[i]   = mwin(addr, lm[i]);
            ecnt[i] = 0;
            vcnt[i] = 0;
            vrel[i] = -1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [107:0] rnd_addr();
      logic [107:0] a;
      for (int k = 0; k < 9; k++) a[k*12 +: 12] = 12'($urandom);
      return a;
   endfunction

   function automatic logic [11:0] rnd_cen();
      logic [5:0] r, c;
      case ($urandom % 4)
         0: r = 6'd0;
         1: r = 6'd63;
         default: r = 6'($urandom);
      endcase
      case ($urandom % 4)
         0: c = 6'd0;
         1: c = 6'd63;
         default: c = 6'($urandom);
      endcase
      return {r, c};
   endfunction

   task automatic fetch(input logic [11:0] c);
      cen   = c;
      addr  = nb(c);
      start = 1'b1;
      tick();
      start = 1'b0;
      addr  = rnd_addr();
      cen   = 12'($urandom);
   endtask

   task automatic pin(input int i, input logic [71:0] w, input int r, input int n);
      pin_i   = i;
      pin_win = w;
      pin_rel = r;
      pin_nen = n;
      pin_go  = 1'b1;
      tick();
      pin_go  = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      addr    = '0;
      cen     = '0;
      pin_go  = 1'b0;
      pin_i   = 0;
      pin_rel = 0;
      pin_nen = 0;
      pin_win = '0;
      for (int a = 0; a < 4096; a++) mem[a] = 8'(a);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (2) tick();

      // Interior window, all three configurations.
      fetch(12'h821);
      repeat (16) tick();
      pin(0, 72'h626160222120E2E1E0, 11, 9);
      pin(1, 72'h626160222120E2E1E0, 13, 9);
      pin(2, 72'h626160222120E2E1E0, 11, 9);

      // Top-left corner.
      fetch(12'h000);
      repeat (16) tick();
      pin(0, 72'h414000010000000000, 11, 4);
      pin(1, 72'h414000010000000000, 13, 4);
      pin(2, 72'h41403F0100FFC1C0BF, 11, 9);

      // Bottom-right corner.
      fetch(12'hFFF);
      repeat (16) tick();
      pin(0, 72'h00000000FFFE00BFBE, 11, 4);
      pin(2, 72'h403F3E00FFFEC0BFBE, 11, 9);

      // Starts during ISSUE and DONE are ignored.
      fetch(12'h821);
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (6) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (14) tick();
      pin(0, 72'h626160222120E2E1E0, 11, 9);
      pin(1, 72'h626160222120E2E1E0, 13, 9);

      // Reset in the middle of a fetch, then a fresh fetch.
      fetch(12'h821);
      repeat (4) tick();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
      fetch(12'h452);
      repeat (16) tick();
      pin(0, 72'h939291535251131211, 11, 9);
      pin(1, 72'h939291535251131211, 13, 9);

      for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
      for (int n = 0; n < 1500; n++) begin
         rst_n = ($urandom % 80) != 0;
         start = ($urandom % 4) == 0;
         cen   = rnd_cen();
         addr  = (($urandom % 4) == 0) ? rnd_addr() : nb(cen);
         tick();
      end
      rst_n = 1'b1;
      start = 1'b0;
      repeat (20) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
